// File: rtl/qlo_pkg.sv
// Shared definitions for the quadrature LO generator: FSM state encoding,
// the Q15 quarter-wave sine table and the sample scaling helper.
package qlo_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } qlo_state_e;

   // Rounding constant added before the >>15 that rescales a Q15 product.
   localparam int QLO_ROUND = 16384;

   // sin(k * 22.5 deg) in Q15 for k = 0..4, i.e. a 16-phase quarter wave.
   localparam int QLO_QTAB [5] = '{0, 12540, 23170, 30274, 32767};

   // Signed sample for phase p of a 2**phase_w period, scaled to +/-amax.
   // Quarter-wave symmetry folds p into the table; the sign is applied after
   // scaling so the result is symmetric and never reaches -(amax+1).
   function automatic int qlo_sample(input int p, input int phase_w, input int amax);
      int         qtr;
      int         quad;
      int         off;
      int         idx;
      int         mag;
      logic [2:0] tidx;
      qtr  = 1 << (phase_w - 2);
      quad = (p >> (phase_w - 2)) & 3;
      off  = p & (qtr - 1);
      idx  = quad[0] ? (qtr - off) : off;
      tidx = 3'(idx << (4 - phase_w));
      mag  = (QLO_QTAB[tidx] * amax + QLO_ROUND) >> 15;
      return quad[1] ? -mag : mag;
   endfunction

endpackage

// File: rtl/qlo_div.sv
// Step-strobe divider for quad_lo_gen: counts 0..div_q and flags the last
// cycle of each phase step. div_q is re-latched only when a step is taken,
// so a div_ratio change applies from the following step.
module qlo_div #(
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             active,
   input  logic             sync_clr,
   input  logic [DIV_W-1:0] div_ratio,
   output logic             step
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_q;

   assign step = (cnt == div_q);

   // Divider counter and period latch; cleared whenever the LO is not running.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt   <= '0;
         div_q <= '0;
      end else if (start) begin
         cnt   <= '0;
         div_q <= div_ratio;
      end else if (!active || sync_clr) begin
         cnt <= '0;
      end else if (step) begin
         cnt   <= '0;
         div_q <= div_ratio;
      end else begin
         cnt <= cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/quad_lo_gen.sv
// Quadrature local-oscillator generator: steps a phase index every
// div_ratio+1 cycles and emits registered sine/cosine samples from a
// quarter-wave table. Define QLO_SYNC_EN to add the sync_clr phase realign.
module quad_lo_gen
   import qlo_pkg::*;
#(
   parameter int OUT_W   = 2,
   parameter int PHASE_W = 2,
   parameter int DIV_W   = 4
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      en,
   input  logic [DIV_W-1:0]          div_ratio,
   input  logic                      dir,
`ifdef QLO_SYNC_EN
   input  logic                      sync_clr,
`endif
   output logic signed [OUT_W-1:0]   sin_out,
   output logic signed [OUT_W-1:0]   cos_out,
   output logic [PHASE_W-1:0]        phase_out,
   output logic                      tick_o
);

   localparam int AMAX = (1 << (OUT_W - 1)) - 1;
   localparam int QTR  = 1 << (PHASE_W - 2);

   qlo_state_e         state;
   logic               step;
   logic               sync;
   logic               start;
   logic               active;
   logic [PHASE_W-1:0] nxt;

`ifdef QLO_SYNC_EN
   assign sync = sync_clr;
`else
   assign sync = 1'b0;
`endif

   assign start  = (state == IDLE) && en;
   assign active = (state == RUN) && en;
   assign nxt    = dir ? (phase_out - PHASE_W'(1)) : (phase_out + PHASE_W'(1));

   qlo_div #(
      .DIV_W (DIV_W)
   ) u_div (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .active    (active),
      .sync_clr  (active && sync),
      .div_ratio (div_ratio),
      .step      (step)
   );

   // FSM, phase accumulator and registered sample outputs.
   // NOTE: every register here uses <= so all updates see pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         phase_out <= '0;
         sin_out   <= '0;
         cos_out   <= '0;
         tick_o    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  state     <= RUN;
                  phase_out <= '0;
                  sin_out   <= '0;
                  cos_out   <= OUT_W'(AMAX);
                  tick_o    <= 1'b1;
               end else begin
                  phase_out <= '0;
                  sin_out   <= '0;
                  cos_out   <= '0;
                  tick_o    <= 1'b0;
               end
            end
            RUN: begin
               if (!en) begin
                  state     <= IDLE;
                  phase_out <= '0;
                  sin_out   <= '0;
                  cos_out   <= '0;
                  tick_o    <= 1'b0;
               end else if (sync) begin
                  phase_out <= '0;
                  sin_out   <= '0;
                  cos_out   <= OUT_W'(AMAX);
                  tick_o    <= 1'b1;
               end else if (step) begin
                  phase_out <= nxt;
                  sin_out   <= OUT_W'(qlo_sample(int'(nxt), PHASE_W, AMAX));
                  cos_out   <= OUT_W'(qlo_sample(int'(nxt) + QTR, PHASE_W, AMAX));
                  tick_o    <= 1'b1;
               end else begin
                  tick_o <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_quad_lo_gen.sv
// Directed bench for quad_lo_gen: a 2-bit/4-phase instance (a) and a
// 4-bit/8-phase instance (b) driven side by side from one initial block.
module tb_quad_lo_gen;

   logic             clk = 1'b0;
   logic             resetn;
   logic             en_a, dir_a, sync_a;
   logic [3:0]       div_a;
   logic             en_b, dir_b, sync_b;
   logic [3:0]       div_b;
   logic signed [1:0] sin_a, cos_a;
   logic [1:0]       phase_a;
   logic             tick_a;
   logic signed [3:0] sin_b, cos_b;
   logic [2:0]       phase_b;
   logic             tick_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   quad_lo_gen #(.OUT_W(2), .PHASE_W(2), .DIV_W(4)) u_a (
      .clk       (clk),
      .resetn    (resetn),
      .en        (en_a),
      .div_ratio (div_a),
      .dir       (dir_a),
`ifdef QLO_SYNC_EN
      .sync_clr  (sync_a),
`endif
      .sin_out   (sin_a),
      .cos_out   (cos_a),
      .phase_out (phase_a),
      .tick_o    (tick_a)
   );

   quad_lo_gen #(.OUT_W(4), .PHASE_W(3), .DIV_W(4)) u_b (
      .clk       (clk),
      .resetn    (resetn),
      .en        (en_b),
      .div_ratio (div_b),
      .dir       (dir_b),
`ifdef QLO_SYNC_EN
      .sync_clr  (sync_b),
`endif
      .sin_out   (sin_b),
      .cos_out   (cos_b),
      .phase_out (phase_b),
      .tick_o    (tick_b)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input int ph, input int s, input int c, input int t);
      check({tag, ".phase_a"}, int'(phase_a), ph);
      check({tag, ".sin_a"},   int'(sin_a),   s);
      check({tag, ".cos_a"},   int'(cos_a),   c);
      check({tag, ".tick_a"},  int'(tick_a),  t);
   endtask

   task automatic chk_b(input string tag, input int ph, input int s, input int c, input int t);
      check({tag, ".phase_b"}, int'(phase_b), ph);
      check({tag, ".sin_b"},   int'(sin_b),   s);
      check({tag, ".cos_b"},   int'(cos_b),   c);
      check({tag, ".tick_b"},  int'(tick_b),  t);
   endtask

   // One rising edge, then settle before sampling or driving.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sin4 [4] = '{0, 1, 0, -1};
      int cos4 [4] = '{1, 0, -1, 0};
      int sin8 [8] = '{0, 5, 7, 5, 0, -5, -7, -5};
      int cos8 [8] = '{7, 5, 0, -5, -7, -5, 0, 5};
      int dn   [5] = '{0, 3, 2, 1, 0};
      int rev  [6] = '{4, 3, 2, 1, 0, 7};

      resetn = 1'b0;
      en_a = 1'b0; dir_a = 1'b0; sync_a = 1'b0; div_a = 4'd4;
      en_b = 1'b0; dir_b = 1'b0; sync_b = 1'b0; div_b = 4'd0;
      #1;
      chk_a("reset", 0, 0, 0, 0);
      chk_b("reset", 0, 0, 0, 0);
      cyc();
      resetn = 1'b1;
      cyc();
      chk_a("idle", 0, 0, 0, 0);

      // Up-counting LO, 5 cycles per phase, wraps back to phase 0.
      en_a = 1'b1;
      cyc();
      for (int p = 0; p < 5; p++) begin
         for (int k = 0; k < 5; k++) begin
            chk_a($sformatf("up p%0d k%0d", p, k), p % 4, sin4[p % 4], cos4[p % 4], (k == 0) ? 1 : 0);
            cyc();
         end
      end
      en_a = 1'b0;
      cyc();
      chk_a("back_to_idle", 0, 0, 0, 0);

      // Conjugate LO: phase decrements 0,3,2,1,0.
      dir_a = 1'b1;
      en_a  = 1'b1;
      cyc();
      for (int p = 0; p < 5; p++) begin
         for (int k = 0; k < 5; k++) begin
            chk_a($sformatf("down p%0d k%0d", p, k), dn[p], sin4[dn[p]], cos4[dn[p]], (k == 0) ? 1 : 0);
            cyc();
         end
      end
      en_a = 1'b0;
      dir_a = 1'b0;
      cyc();

      // Mid-step div_ratio change 4 -> 1: current step keeps 5 cycles.
      div_a = 4'd4;
      en_a  = 1'b1;
      cyc();
      chk_a("div k0", 0, 0, 1, 1);
      div_a = 4'd1;
      for (int k = 1; k < 5; k++) begin
         cyc();
         chk_a($sformatf("div k%0d", k), 0, 0, 1, 0);
      end
      cyc(); chk_a("div p1a", 1, 1, 0, 1);
      cyc(); chk_a("div p1b", 1, 1, 0, 0);
      cyc(); chk_a("div p2a", 2, 0, -1, 1);
      cyc(); chk_a("div p2b", 2, 0, -1, 0);
      cyc(); chk_a("div p3a", 3, -1, 0, 1);

      // 8-phase, 4-bit LO stepping every cycle, then a direction reversal.
      en_b = 1'b1;
      cyc();
      for (int i = 0; i < 12; i++) begin
         chk_b($sformatf("fast i%0d", i), i % 8, sin8[i % 8], cos8[i % 8], 1);
         cyc();
      end
      // Now at phase 4; reversing takes effect from the next step.
      dir_b = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk_b($sformatf("rev i%0d", i), rev[i], sin8[rev[i]], cos8[rev[i]], 1);
         cyc();
      end
      en_b = 1'b0;
      dir_b = 1'b0;
      cyc();
      chk_b("b_idle", 0, 0, 0, 0);

`ifdef QLO_SYNC_EN
      // sync_clr on the cycle a step would happen at phase 2.
      en_a = 1'b0;
      cyc();
      div_a = 4'd1;
      en_a  = 1'b1;
      cyc(); chk_a("sync p0", 0, 0, 1, 1);
      cyc();
      cyc(); chk_a("sync p1", 1, 1, 0, 1);
      cyc();
      cyc(); chk_a("sync p2a", 2, 0, -1, 1);
      cyc(); chk_a("sync p2b", 2, 0, -1, 0);
      sync_a = 1'b1;
      cyc(); chk_a("sync hit", 0, 0, 1, 1);
      sync_a = 1'b0;
      cyc(); chk_a("sync after", 0, 0, 1, 0);
      cyc(); chk_a("sync next", 1, 1, 0, 1);
      // en=0 beats a coincident sync_clr; sync_clr in IDLE is ignored.
      en_a = 1'b0;
      sync_a = 1'b1;
      cyc(); chk_a("sync en0", 0, 0, 0, 0);
      cyc(); chk_a("sync idle", 0, 0, 0, 0);
      sync_a = 1'b0;
`endif

      // Asynchronous reset in the middle of a run, then restart at phase 0.
      en_a = 1'b0;
      cyc();
      div_a = 4'd4;
      en_a  = 1'b1;
      repeat (7) cyc();
      chk_a("pre_rst", 1, 1, 0, 0);
      #2;
      resetn = 1'b0;
      #1;
      chk_a("async_rst", 0, 0, 0, 0);
      #2;
      resetn = 1'b1;
      cyc(); chk_a("restart k0", 0, 0, 1, 1);
      cyc(); chk_a("restart k1", 0, 0, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
